// File: rtl/multibyte_sub_ctrl.sv
// -----------------------------------------------------------------------------
// multibyte_sub_ctrl
//
// Sequences a wide subtraction (op_a - op_b - borrow_in) through an external
// byte-wide subtractor, one byte per round trip, least significant byte first.
// The borrow out of each byte is chained into the next byte's request. When
// the top byte has been captured, ack pulses for one cycle. result/borrow_out
// then hold until the next request is accepted.
//
// Parameters
//   DATA_WIDTH  byte width (the ALU's byte width, default 8)
//   NUM_BYTES   operand width in bytes (2..16, default 4)
//
// Optional build macro
//   SUB_SATURATE_EN  when defined, a final borrow of 1 forces result to 0
//                    (unsigned saturation). borrow_out still reports 1.
//                    When undefined, result is the raw wrap-around difference.
//
// Ports
//   clk                single clock, rising-edge
//   rst_n              asynchronous active-low reset
//   req_i              operation request, sampled only while idle
//   op_a_i, op_b_i     minuend / subtrahend (NUM_BYTES*DATA_WIDTH)
//   borrow_in_i        initial borrow into byte 0
//   busy_o             high whenever an operation is in progress
//   ack_o              one-cycle pulse, result_o/borrow_out_o valid
//   result_o           op_a - op_b - borrow_in (no extension bit)
//   borrow_out_o       final borrow out of the top byte
//   byte_a_o, byte_b_o operand bytes to the byte subtractor
//   byte_borrow_in_o   chained borrow to the byte subtractor
//   start_o            one-cycle issue strobe to the byte subtractor
//   byte_diff_i        byte subtractor difference
//   byte_borrow_out_i  byte subtractor borrow out
//   done_i             byte subtractor response valid
// -----------------------------------------------------------------------------
module multibyte_sub_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_i,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] op_a_i,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] op_b_i,
    input  logic                            borrow_in_i,
    output logic                            busy_o,
    output logic                            ack_o,
    output logic [NUM_BYTES*DATA_WIDTH-1:0] result_o,
    output logic                            borrow_out_o,
    output logic [DATA_WIDTH-1:0]           byte_a_o,
    output logic [DATA_WIDTH-1:0]           byte_b_o,
    output logic                            byte_borrow_in_o,
    output logic                            start_o,
    input  logic [DATA_WIDTH-1:0]           byte_diff_i,
    input  logic                            byte_borrow_out_i,
    input  logic                            done_i
);

    localparam int OP_W  = NUM_BYTES * DATA_WIDTH;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_e;

    state_e           state_q,      state_d;
    logic [IDX_W-1:0] idx_q,        idx_d;
    logic [OP_W-1:0]  op_a_q,       op_a_d;
    logic [OP_W-1:0]  op_b_q,       op_b_d;
    logic             chain_q,      chain_d;
    logic [OP_W-1:0]  result_q,     result_d;
    logic             borrow_out_q, borrow_out_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            chain_q      <= 1'b0;
            result_q     <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            chain_q      <= chain_d;
            result_q     <= result_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first; any path that skipped an
        // assignment would otherwise infer a latch.
        state_d          = state_q;
        idx_d            = idx_q;
        op_a_d           = op_a_q;
        op_b_d           = op_b_q;
        chain_d          = chain_q;
        result_d         = result_q;
        borrow_out_d     = borrow_out_q;
        busy_o           = (state_q != S_IDLE);
        ack_o            = (state_q == S_FINISH);
        start_o          = (state_q == S_ISSUE);
        byte_a_o         = '0;
        byte_b_o         = '0;
        byte_borrow_in_o = 1'b0;

        // Operand byte and chained borrow are a function of registered state
        // only, so they stay stable from ISSUE through the capturing WAIT cycle.
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            byte_a_o         = op_a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
            byte_b_o         = op_b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
            byte_borrow_in_o = chain_q;
        end

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_a_d       = op_a_i;
                    op_b_d       = op_b_i;
                    chain_d      = borrow_in_i;
                    result_d     = '0;
                    borrow_out_d = 1'b0;
                    idx_d        = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A done seen here belongs to no request of ours; ignore it.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_i) begin
                    result_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = byte_diff_i;
                    chain_d = byte_borrow_out_i;
                    if (idx_q == LAST_IDX) begin
                        // Final borrow and (optional) saturation are resolved
                        // on entry to FINISH so they are visible with ack.
                        borrow_out_d = byte_borrow_out_i;
`ifdef SUB_SATURATE_EN
                        if (byte_borrow_out_i) begin
                            result_d = '0;
                        end
`endif
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result_o     = result_q;
    assign borrow_out_o = borrow_out_q;

endmodule
